sync_down_counter: RTL and testbench

Synchronous, loadable, parameterized down counter with a valid/ready period-load handshake, a terminal-count pulse and a divided-clock output. All state changes on `clk_i` only; no derived clocks, unlike ripple-style counters. It serves as the programmable countdown/divider companion to the free-running up counters in Counters_Dividers and drives timeouts and clock-enable generation in downstream logic.

---
 rtl/sync_down_counter.sv | 74 +++++++
 tb/tb_sync_down_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable down counter with a period-load handshake,
// registered terminal-count pulse and a divided output that toggles on each pulse.
module sync_down_counter #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             load_ready_o,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             div_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, per_q, per_d;
  logic             tc_q, tc_d, div_q, div_d, load;
  assign load_ready_o = (state_q != RUN) || AUTO_RELOAD;
  assign busy_o       = state_q == RUN;
  assign load         = load_valid_i && load_ready_o;
  assign q_o          = q_q;
  assign tc_o         = tc_q;
  assign div_o        = div_q;
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    per_d   = per_q;
    tc_d    = 1'b0;
    if (clr_i) begin
      state_d = IDLE;
      q_d     = '0;
      per_d   = '0;
    end else if (load && state_q != RUN) begin
      q_d     = load_val_i;
      per_d   = load_val_i;
      state_d = (load_val_i == '0 && !AUTO_RELOAD) ? DONE : RUN;
      tc_d    = load_val_i == '0;
    end else begin
      // a load while running only retargets the next reload; the current reload uses the old period
      if (load) per_d = load_val_i;
      if (state_q == RUN && en_i) begin
        if (q_q != '0) begin
          q_d  = q_q - WIDTH'(1);
          tc_d = q_q == WIDTH'(1);
          if (!AUTO_RELOAD && q_q == WIDTH'(1)) state_d = DONE;
        end else if (AUTO_RELOAD) begin
          q_d  = per_q;
          tc_d = per_q == '0;
        end
      end
    end
    div_d = clr_i ? 1'b0 : div_q ^ tc_d;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      per_q   <= '0;
      tc_q    <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      per_q   <= per_d;
      tc_q    <= tc_d;
      div_q   <= div_d;
    end
  end
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: drives a one-shot and an auto-reload instance with shared
// directed stimulus, checking both against a behavioural model every cycle.
module tb_sync_down_counter;
  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       clr = 1'b0, en = 1'b0, lv = 1'b0;
  logic [3:0] lval = '0;
  logic [3:0] q0, q1;
  logic       tc0, tc1, div0, div1, busy0, busy1, rdy0, rdy1;
  int         checks = 0, errors = 0;
  int         mq[2], mper[2], mst[2];
  bit         mtc[2], mdiv[2];

  always #5 clk_i = ~clk_i;

  sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) u0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr), .en_i(en), .load_valid_i(lv),
    .load_val_i(lval), .load_ready_o(rdy0), .q_o(q0), .tc_o(tc0), .div_o(div0), .busy_o(busy0));
  sync_down_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) u1 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr), .en_i(en), .load_valid_i(lv),
    .load_val_i(lval), .load_ready_o(rdy1), .q_o(q1), .tc_o(tc1), .div_o(div1), .busy_o(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model state: 0 idle, 1 running, 2 one-shot finished
  task automatic model_step(input int i);
    int old_per;
    bit ar, ready, hit;
    ar = i == 1;
    ready = mst[i] != 1 || ar;
    hit = 1'b0;
    old_per = mper[i];
    if (clr) begin
      mq[i] = 0; mper[i] = 0; mst[i] = 0; mdiv[i] = 1'b0;
    end else begin
      if (lv && ready) mper[i] = int'(lval);
      if (lv && ready && mst[i] != 1) begin
        mq[i] = int'(lval);
        mst[i] = (lval == 0 && !ar) ? 2 : 1;
        hit = lval == 0;
      end else if (mst[i] == 1 && en) begin
        if (mq[i] > 0) begin
          mq[i] = mq[i] - 1;
          hit = mq[i] == 0;
          if (hit && !ar) mst[i] = 2;
        end else begin
          mq[i] = old_per;
          hit = old_per == 0;
        end
      end
    end
    mtc[i] = hit;
    if (hit) mdiv[i] = !mdiv[i];
  endtask

  always @(posedge clk_i or negedge rst_n_i) begin
    for (int i = 0; i < 2; i++)
      if (!rst_n_i) begin
        mq[i] = 0; mper[i] = 0; mst[i] = 0; mtc[i] = 1'b0; mdiv[i] = 1'b0;
      end else model_step(i);
    #1;
    chk("m_q0", q0, mq[0]);       chk("m_q1", q1, mq[1]);
    chk("m_tc0", tc0, mtc[0]);    chk("m_tc1", tc1, mtc[1]);
    chk("m_div0", div0, mdiv[0]); chk("m_div1", div1, mdiv[1]);
    chk("m_busy0", busy0, mst[0] == 1); chk("m_busy1", busy1, mst[1] == 1);
    chk("m_rdy0", rdy0, mst[0] != 1);   chk("m_rdy1", rdy1, 1);
  end

  task automatic cyc(input logic c, input logic e, input logic v, input logic [3:0] val);
    @(negedge clk_i);
    clr = c; en = e; lv = v; lval = val;
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    int en_pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int q_exp[7]  = '{3, 3, 3, 2, 1, 1, 0};
    int ntc, nhigh, last, first;
    @(posedge clk_i);
    #2;
    chk("rst_q0", q0, 0); chk("rst_rdy0", rdy0, 1); chk("rst_busy1", busy1, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    // reset mid-count
    cyc(0, 0, 1, 5);
    chk("ld5_q1", q1, 5); chk("ld5_rdy0", rdy0, 0); chk("ld5_busy0", busy0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("cnt_q0", q0, 3);
    #1 rst_n_i = 1'b0;
    #1;
    chk("arst_q0", q0, 0); chk("arst_q1", q1, 0); chk("arst_tc0", tc0, 0);
    chk("arst_div1", div1, 0); chk("arst_rdy0", rdy0, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    // one-shot
    cyc(0, 0, 1, 3);
    chk("os_q0", q0, 3);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("os_q0_1", q0, 1); chk("os_busy0", busy0, 1);
    cyc(0, 1, 0, 0);
    chk("os_end_q0", q0, 0); chk("os_end_tc0", tc0, 1);
    chk("os_end_busy0", busy0, 0); chk("os_end_rdy0", rdy0, 1); chk("ar_div1", div1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 0);
      chk("os_hold_q0", q0, 0); chk("os_hold_tc0", tc0, 0);
    end
    cyc(0, 0, 1, 6);
    chk("os_reload_q0", q0, 6);
    cyc(0, 0, 1, 2);
    chk("os_run_ld_q0", q0, 6); chk("ar_run_ld_q1", q1, 3);
    // clear beats load
    cyc(1, 0, 1, 9);
    chk("clr_q1", q1, 0); chk("clr_busy1", busy1, 0); chk("clr_q0", q0, 0);
    cyc(0, 1, 0, 0);
    chk("clr_drop_q0", q0, 0); chk("clr_drop_busy0", busy0, 0);
    // enable gating
    cyc(0, 0, 1, 4);
    for (int k = 0; k < 7; k++) begin
      cyc(0, en_pat[k][0], 0, 0);
      chk("gate_q0", q0, q_exp[k]); chk("gate_q1", q1, q_exp[k]);
    end
    chk("gate_tc0", tc0, 1); chk("gate_busy0", busy0, 0);
    cyc(1, 0, 0, 0);
    // zero load
    cyc(0, 0, 1, 0);
    chk("z_tc0", tc0, 1); chk("z_busy0", busy0, 0); chk("z_tc1", tc1, 1); chk("z_busy1", busy1, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0);
      chk("z_tc0_low", tc0, 0); chk("z_tc1_each", tc1, 1); chk("z_div1", div1, k % 2 == 0 ? 0 : 1);
    end
    cyc(1, 0, 0, 0);
    // divider with period 15
    cyc(0, 0, 1, 15);
    ntc = 0; nhigh = 0; last = 0; first = 0;
    for (int k = 1; k <= 64; k++) begin
      cyc(0, 1, 0, 0);
      if (tc1) begin
        ntc++;
        if (last > 0) chk("div_gap", k - last, 16);
        else first = k;
        last = k;
      end
      if (div1) nhigh++;
    end
    chk("div_first", first, 15); chk("div_ntc", ntc, 4); chk("div_high", nhigh, 32);
    cyc(1, 0, 0, 0);
    // load in run coinciding with reload
    cyc(0, 0, 1, 4);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
    chk("sim_q1_0", q1, 0);
    cyc(0, 1, 1, 2);
    chk("sim_reload_old", q1, 4); chk("sim_q0_ld", q0, 2);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("sim_reload_new", q1, 2);
    cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
